// File: rtl/audio_dac_i2s_tx.sv
// I2S transmitter: 2-deep stereo sample FIFO feeding a 32-BCLK frame serializer.
// Frame loads one BCLK falling edge after bit 31; in_ready drops only when both FIFO slots are full.
module audio_dac_i2s_tx #(
    parameter int BCLK_DIV = 16
) (
    input  logic        OSC_50_B3B,
    input  logic        RESET_n,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_left,
    input  logic [15:0] in_right,
    input  logic        underrun_clr,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        frame_start,
    output logic        underrun,
    output logic [1:0]  fifo_level
);
    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } pair_t;

    pair_t      in_pair;
    pair_t      head_q, head_d;
    pair_t      tail_q, tail_d;
    pair_t      frame_q, frame_d;
    logic [1:0] level_q, level_d;
    logic [7:0] divcnt_q, divcnt_d;
    logic [4:0] k_q, k_d;
    logic       bclk_q, bclk_d;
    logic       lrck_q, lrck_d;
    logic       dat_q, dat_d;
    logic       fs_q, fs_d;
    logic       underrun_q, underrun_d;

    logic       push, pop, bclk_tgl, bclk_fall, load;
    logic [3:0] bit_idx;

    assign in_pair = {in_left, in_right};

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        frame_d    = frame_q;
        level_d    = level_q;
        divcnt_d   = divcnt_q;
        k_d        = k_q;
        bclk_d     = bclk_q;
        lrck_d     = lrck_q;
        dat_d      = dat_q;
        underrun_d = underrun_q;
        bit_idx    = 4'd0;

        push      = in_valid && (level_q != 2'd2);
        bclk_tgl  = enable && (divcnt_q == DIV_LAST);
        bclk_fall = bclk_tgl && bclk_q;
        load      = bclk_fall && (k_q == 5'd31);
        pop       = load && (level_q != 2'd0);
        fs_d      = load;

        // Simultaneous push and pop can only happen at level 1: the new pair becomes the head.
        if (push && pop) begin
            head_d = in_pair;
        end else if (pop) begin
            head_d  = tail_q;
            level_d = level_q - 2'd1;
        end else if (push) begin
            if (level_q == 2'd0) begin
                head_d = in_pair;
            end else begin
                tail_d = in_pair;
            end
            level_d = level_q + 2'd1;
        end

        if (!enable) begin
            divcnt_d = 8'd0;
            bclk_d   = 1'b0;
            k_d      = 5'd31;
            frame_d  = '0;
            lrck_d   = 1'b0;
            dat_d    = 1'b0;
        end else begin
            divcnt_d = bclk_tgl ? 8'd0 : divcnt_q + 8'd1;
            if (bclk_tgl) begin
                bclk_d = ~bclk_q;
            end
            if (bclk_fall) begin
                k_d    = k_q + 5'd1;
                lrck_d = k_d[4];
                if (load) begin
                    frame_d = pop ? head_q : '0;
                end
                // 16-k (left) and 32-k (right) both reduce to -k modulo 16.
                bit_idx = 4'd0 - k_d[3:0];
                if (k_d == 5'd0) begin
                    dat_d = frame_q.right[0];
                end else if (k_d <= 5'd16) begin
                    dat_d = frame_d.left[bit_idx];
                end else begin
                    dat_d = frame_d.right[bit_idx];
                end
            end
        end

        if (load && !pop) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge OSC_50_B3B or negedge RESET_n) begin
        if (!RESET_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            frame_q    <= '0;
            level_q    <= 2'd0;
            divcnt_q   <= 8'd0;
            k_q        <= 5'd31;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            dat_q      <= 1'b0;
            fs_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            frame_q    <= frame_d;
            level_q    <= level_d;
            divcnt_q   <= divcnt_d;
            k_q        <= k_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            fs_q       <= fs_d;
            underrun_q <= underrun_d;
        end
    end

    assign in_ready    = (level_q != 2'd2);
    assign fifo_level  = level_q;
    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;
    assign frame_start = fs_q;
    assign underrun    = underrun_q;
endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Bench for audio_dac_i2s_tx: default divider instance plus a BCLK_DIV=2 instance.
`timescale 1ns/1ps
module tb_audio_dac_i2s_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, in_valid, underrun_clr;
    logic [15:0] in_left, in_right;
    logic        in_ready, bclk, lrck, dat, frame_start, underrun;
    logic [1:0]  fifo_level;
    logic        en2, v2, clr2;
    logic [15:0] l2, r2;
    logic        in_ready2, bclk2, lrck2, dat2, frame_start2, underrun2;
    logic [1:0]  fifo_level2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [1:0]  cap_q[$];
    logic [1:0]  exp_q[$];
    logic [31:0] acc_q[$];
    logic        model_prev;

    always #10 clk = ~clk;

    audio_dac_i2s_tx dut (
        .OSC_50_B3B(clk), .RESET_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
        .underrun_clr(underrun_clr), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck),
        .AUD_DACDAT(dat), .frame_start(frame_start), .underrun(underrun),
        .fifo_level(fifo_level)
    );

    audio_dac_i2s_tx #(.BCLK_DIV(2)) dut2 (
        .OSC_50_B3B(clk), .RESET_n(rst_n), .enable(en2), .in_valid(v2),
        .in_ready(in_ready2), .in_left(l2), .in_right(r2),
        .underrun_clr(clr2), .AUD_BCLK(bclk2), .AUD_DACLRCK(lrck2),
        .AUD_DACDAT(dat2), .frame_start(frame_start2), .underrun(underrun2),
        .fifo_level(fifo_level2)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        enable = 0; in_valid = 0; in_left = 0; in_right = 0; underrun_clr = 0;
        en2 = 0; v2 = 0; l2 = 0; r2 = 0; clr2 = 0;
        rst_n = 0;
        tick; tick;
        rst_n = 1;
        tick;
    endtask

    // Reference: each frame is the word {previous R[0], L, R[15:1]} sent MSB first, LRCK high for bits 16..31.
    task automatic model_reset;
        exp_q.delete();
        model_prev = 1'b0;
    endtask

    task automatic model_frame(input logic [15:0] l, input logic [15:0] r);
        logic [31:0] word;
        logic        lr;
        word = {model_prev, l, r[15:1]};
        for (int j = 0; j < 32; j++) begin
            lr = (j >= 16);
            exp_q.push_back({lr, word[31 - j]});
        end
        model_prev = r[0];
    endtask

    task automatic capture(input int n);
        logic pb;
        int   t;
        cap_q.delete();
        pb = bclk;
        t  = 0;
        while (cap_q.size() < n && t < n * 80 + 200) begin
            tick;
            t++;
            if (!pb && bclk) cap_q.push_back({lrck, dat});
            pb = bclk;
        end
    endtask

    task automatic test_reset;
        enable = 0; in_valid = 1; in_left = 16'h1234; in_right = 16'h5678; underrun_clr = 0;
        en2 = 0; v2 = 0; l2 = 0; r2 = 0; clr2 = 0;
        rst_n = 0;
        tick; tick;
        n_checks++;
        if (in_ready !== 1'b1 || fifo_level !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_fifo: in_ready=%b level=%0d want 1/0", in_ready, fifo_level);
        end
        n_checks++;
        if ({bclk, lrck, dat, frame_start, underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: {bclk,lrck,dat,fs,ur}=%b want 00000", {bclk, lrck, dat, frame_start, underrun});
        end
        n_checks++;
        if (in_ready2 !== 1'b1 || fifo_level2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_dut2: in_ready=%b level=%0d want 1/0", in_ready2, fifo_level2);
        end
        rst_n = 1;
        tick;
        in_valid = 0;
        n_checks++;
        if (fifo_level !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_first_edge_push: level=%0d want 1", fifo_level);
        end
    endtask

    task automatic test_basic;
        logic fs_early;
        do_reset;
        model_reset;
        in_left = 16'hA5C3; in_right = 16'h3C5A; in_valid = 1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", in_ready); end
        tick;
        in_valid = 0;
        enable = 1;
        fs_early = 0;
        for (int i = 1; i < 32; i++) begin
            tick;
            if (frame_start) fs_early = 1;
        end
        n_checks++;
        if (fs_early !== 1'b0) begin n_fail++; $display("FAIL basic_fs_early: frame_start seen before clock 32"); end
        tick;
        n_checks++;
        if (frame_start !== 1'b1 || fifo_level !== 2'd0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_load32: fs=%b level=%0d ur=%b want 1/0/0", frame_start, fifo_level, underrun);
        end
        model_frame(16'hA5C3, 16'h3C5A);
        model_frame(16'h0000, 16'h0000);
        capture(64);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_len: got %0d bits want %0d", cap_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL basic_bit[%0d] {lrck,dat}: got %b want %b", i, cap_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL basic_underrun_2nd: got %b want 1", underrun); end
    endtask

    task automatic test_fifo_full;
        logic [15:0] pl[3];
        logic [15:0] pr[3];
        logic        found;
        do_reset;
        model_reset;
        for (int p = 0; p < 3; p++) begin
            pl[p] = 16'($urandom); pr[p] = 16'($urandom);
            in_left = pl[p]; in_right = pr[p]; in_valid = 1;
            n_checks++;
            if (in_ready !== (p < 2)) begin
                n_fail++;
                $display("FAIL full_ready[%0d]: got %b want %b", p, in_ready, (p < 2));
            end
            tick;
        end
        in_valid = 0;
        n_checks++;
        if (fifo_level !== 2'd2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_level: level=%0d ready=%b want 2/0", fifo_level, in_ready);
        end
        enable = 1;
        found = 0;
        for (int t = 0; t < 64 && !found; t++) begin tick; if (frame_start) found = 1; end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL full_fs: no frame_start within 64 clocks"); end
        model_frame(pl[0], pr[0]);
        model_frame(pl[1], pr[1]);
        capture(64);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL full_len: got %0d bits want %0d", cap_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL full_bit[%0d] {lrck,dat}: got %b want %b", i, cap_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (fifo_level !== 2'd0) begin n_fail++; $display("FAIL full_drain: level=%0d want 0", fifo_level); end
    endtask

    task automatic test_push_pop_same;
        logic [15:0] al, ar, bl, br;
        do_reset;
        model_reset;
        al = 16'($urandom); ar = 16'($urandom); bl = 16'($urandom); br = 16'($urandom);
        in_left = al; in_right = ar; in_valid = 1;
        tick;
        in_valid = 0;
        enable = 1;
        for (int i = 1; i < 32; i++) tick;
        in_left = bl; in_right = br; in_valid = 1;
        n_checks++;
        if (in_ready !== 1'b1 || fifo_level !== 2'd1) begin
            n_fail++;
            $display("FAIL pp_pre: ready=%b level=%0d want 1/1", in_ready, fifo_level);
        end
        tick;
        in_valid = 0;
        n_checks++;
        if (frame_start !== 1'b1 || fifo_level !== 2'd1) begin
            n_fail++;
            $display("FAIL pp_level: fs=%b level=%0d want 1/1", frame_start, fifo_level);
        end
        model_frame(al, ar);
        model_frame(bl, br);
        capture(64);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL pp_len: got %0d bits want %0d", cap_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL pp_bit[%0d] {lrck,dat}: got %b want %b", i, cap_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (fifo_level !== 2'd0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_end: level=%0d ur=%b want 0/0", fifo_level, underrun);
        end
    endtask

    task automatic test_underrun;
        int fs_cyc;
        do_reset;
        model_reset;
        enable = 1;
        for (int i = 1; i <= 32; i++) tick;
        fs_cyc = cyc;
        n_checks++;
        if (frame_start !== 1'b1 || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ur_first: fs=%b ur=%b want 1/1", frame_start, underrun);
        end
        model_frame(16'h0000, 16'h0000);
        capture(32);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ur_len: got %0d bits want %0d", cap_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL ur_bit[%0d] {lrck,dat}: got %b want %b", i, cap_q[i], exp_q[i]);
                end
            end
        end
        for (int t = 0; t < 2000 && cyc < fs_cyc + 1023; t++) tick;
        underrun_clr = 1;
        tick;
        n_checks++;
        if (frame_start !== 1'b1 || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ur_set_priority: fs=%b ur=%b want 1/1", frame_start, underrun);
        end
        tick;
        underrun_clr = 0;
        n_checks++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear: got %b want 0", underrun); end
    endtask

    task automatic test_disable_midframe;
        logic [15:0] al, ar, bl, br;
        logic        found, pb, fs_early;
        int          falls;
        do_reset;
        model_reset;
        al = 16'($urandom); ar = 16'($urandom) | 16'h0001;
        bl = 16'($urandom); br = 16'($urandom);
        in_left = al; in_right = ar; in_valid = 1;
        tick;
        in_left = bl; in_right = br;
        tick;
        in_valid = 0;
        enable = 1;
        found = 0;
        for (int t = 0; t < 64 && !found; t++) begin tick; if (frame_start) found = 1; end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL dis_fs: no frame_start within 64 clocks"); end
        pb = bclk;
        falls = 0;
        for (int t = 0; t < 800 && falls < 20; t++) begin
            tick;
            if (pb && !bclk) falls++;
            pb = bclk;
        end
        n_checks++;
        if (falls != 20 || lrck !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_k20: falls=%0d lrck=%b want 20/1", falls, lrck);
        end
        enable = 0;
        tick;
        n_checks++;
        if ({bclk, lrck, dat} !== 3'b000) begin
            n_fail++;
            $display("FAIL dis_outputs: {bclk,lrck,dat}=%b want 000", {bclk, lrck, dat});
        end
        n_checks++;
        if (fifo_level !== 2'd1 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_kept: level=%0d ur=%b want 1/0", fifo_level, underrun);
        end
        for (int i = 0; i < 5; i++) tick;
        enable = 1;
        fs_early = 0;
        for (int i = 1; i < 32; i++) begin tick; if (frame_start) fs_early = 1; end
        tick;
        n_checks++;
        if (fs_early !== 1'b0 || frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_reenable_fs: early=%b fs@32=%b want 0/1", fs_early, frame_start);
        end
        model_frame(bl, br);
        capture(32);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL dis_len: got %0d bits want %0d", cap_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL dis_bit[%0d] {lrck,dat}: got %b want %b", i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_bclk_div2;
        logic pb, pl, started;
        int   last_b, last_l;
        do_reset;
        model_reset;
        acc_q.delete();
        cap_q.delete();
        for (int p = 0; p < 2; p++) begin
            l2 = 16'($urandom); r2 = 16'($urandom); v2 = 1;
            if (in_ready2) acc_q.push_back({l2, r2});
            tick;
        end
        v2 = 0;
        en2 = 1;
        pb = bclk2; pl = lrck2; started = 0;
        last_b = -1; last_l = -1;
        for (int t = 0; t < 700 && cap_q.size() < 128; t++) begin
            v2 = ($urandom_range(0, 3) == 0);
            l2 = 16'($urandom); r2 = 16'($urandom);
            if (v2 && in_ready2) acc_q.push_back({l2, r2});
            tick;
            if (bclk2 !== pb) begin
                if (last_b >= 0) begin
                    n_checks++;
                    if (cyc - last_b != 2) begin
                        n_fail++;
                        $display("FAIL div2_bclk_half: got %0d clocks want 2", cyc - last_b);
                    end
                end
                last_b = cyc;
            end
            if (lrck2 && !pl) begin
                if (last_l >= 0) begin
                    n_checks++;
                    if (cyc - last_l != 128) begin
                        n_fail++;
                        $display("FAIL div2_lrck_period: got %0d clocks want 128", cyc - last_l);
                    end
                end
                last_l = cyc;
            end
            if (started && bclk2 && !pb) cap_q.push_back({lrck2, dat2});
            if (frame_start2) started = 1;
            pb = bclk2;
            pl = lrck2;
        end
        v2 = 0;
        n_checks++;
        if (acc_q.size() < 4) begin
            n_fail++;
            $display("FAIL div2_accepted: got %0d pairs want >= 4", acc_q.size());
        end else begin
            for (int f = 0; f < 4; f++) model_frame(acc_q[f][31:16], acc_q[f][15:0]);
            n_checks++;
            if (cap_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL div2_len: got %0d bits want %0d", cap_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_checks++;
                    if (cap_q[i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL div2_bit[%0d] {lrck,dat}: got %b want %b", i, cap_q[i], exp_q[i]);
                    end
                end
            end
        end
        n_checks++;
        if (underrun2 !== 1'b0) begin n_fail++; $display("FAIL div2_underrun: got %b want 0", underrun2); end
        en2 = 0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_fifo_full;
        test_push_pop_same;
        test_underrun;
        test_disable_midframe;
        test_bclk_div2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_dac_i2s_tx.md
AUDIO_DAC_I2S_TX -- requirements
Module: audio_dac_i2s_tx

Interface
REQ-001 Parameter BCLK_DIV, default 16: system clocks per AUD_BCLK half-period, legal range 2..255.
REQ-002 OSC_50_B3B  input  1  the single system clock, 50 MHz; all logic is on its rising edge.
REQ-003 RESET_n  input  1  reset, asynchronous and active-low.
REQ-004 enable  input  1  1 = run the serial interface; 0 = idle the interface.
REQ-005 in_valid  input  1  a stereo sample pair is present on in_left and in_right.
REQ-006 in_ready  output  1  the block can accept a sample pair this cycle.
REQ-007 in_left  input  16  left sample, two's complement.
REQ-008 in_right  input  16  right sample, two's complement.
REQ-009 underrun_clr  input  1  clears the sticky underrun flag.
REQ-010 AUD_BCLK  output  1  I2S bit clock to the codec.
REQ-011 AUD_DACLRCK  output  1  I2S word select: 0 = left, 1 = right.
REQ-012 AUD_DACDAT  output  1  I2S serial data, MSB first.
REQ-013 frame_start  output  1  one-cycle pulse when a frame is loaded.
REQ-014 underrun  output  1  sticky flag: a frame was loaded while the FIFO was empty.
REQ-015 fifo_level  output  2  number of pairs held, 0..2.

Function
REQ-016 Input buffer: 2-entry FIFO of {left,right}; push when in_valid & in_ready; in_ready = (fifo_level != 2), decoded from registered state only.
REQ-017 Push and pop in the same cycle at level 1: level stays 1, data order is preserved; at level 2, no push is possible.
REQ-018 The FIFO accepts pushes regardless of enable.
REQ-019 Divider: counter 0..BCLK_DIV-1 runs while enable=1; at terminal count it wraps and AUD_BCLK toggles; BCLK period = 2*BCLK_DIV clocks (default 32 clocks, 1.5625 MHz).
REQ-020 Bit counter k, 5 bits, advances modulo 32 only on a cycle where AUD_BCLK toggles 1->0; a frame is 32 BCLKs (default 1024 clocks, ~48.83 kHz).
REQ-021 AUD_DACLRCK and AUD_DACDAT update only on BCLK falling-edge cycles, in the same cycle as k.
REQ-022 AUD_DACLRCK = 1 when the new k is in 16..31, else 0.
REQ-023 AUD_DACDAT for new k: k=0 -> R[0] of the previous frame; k=1..16 -> L[16-k]; k=17..31 -> R[32-k] (standard I2S one-bit delay).
REQ-024 Frame load on the falling edge that wraps k 31->0: if fifo_level>0, pop the head into {L,R}; otherwise load {L,R}=0 and set underrun; frame_start=1 for that cycle.
REQ-025 The previous R[0] is retained for the k=0 bit of the new frame.
REQ-026 underrun: set has priority over underrun_clr in the same cycle; otherwise underrun_clr=1 clears it.
REQ-027 Idle state: enable=1 leaves idle with divcnt=0, AUD_BCLK=0, k=31, previous R=0; the first falling edge at 2*BCLK_DIV clocks performs a load.
REQ-028 enable=0, including mid-frame: the next cycle forces AUD_BCLK, AUD_DACLRCK and AUD_DACDAT to 0, returns to the idle state, and discards the loaded {L,R}; FIFO contents and underrun are kept.

Reset
REQ-029 While RESET_n=0, the block clears the FIFO, level, divider, k=31, {L,R}, previous R, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start and underrun; in_ready=1.
REQ-030 After RESET_n deasserts, the first active edge of OSC_50_B3B is handled normally.

Verification
REQ-031 Reset then push L=16'hA5C3, R=16'h3C5A, then enable=1 -> frame_start at clock 32; AUD_DACDAT sampled at BCLK rising edges reads 0,A5C3 MSB-first,3C5A[15:1], then bit 0 of the next frame is 0.
REQ-032 Push 3 pairs back to back with enable=0 -> accepts 2, in_ready=0 on the 3rd attempt, fifo_level=2.
REQ-033 Level 1 with a push coinciding with a frame load -> level stays 1 and the popped data is the older pair.
REQ-034 Enable with an empty FIFO -> frame loads zeros and underrun=1; underrun_clr asserted on a later load cycle -> underrun remains 1.
REQ-035 enable dropped at k=20 -> next cycle BCLK, LRCK and DAT are 0; re-enable -> first frame_start after 32 clocks, pushed data intact.
REQ-036 BCLK_DIV=2 -> BCLK period 4 clocks, LRCK period 128 clocks, no bit slips over 4 frames.
